a2d_spi_resp: RTL

SPI responder modelling the 8-channel, 12-bit A2D converter that the Segway's A2D interface polls for load cells, steering pot and battery. It is the slave end of that SPI link. It decodes the 3-bit channel command in each 16-bit frame and returns that channel's conversion in the following frame. It is used in the full-chip bench and in FPGA loop-back builds, driven from per-channel value inputs.

---
 rtl/a2d_spi_resp_pkg.sv | 12 +
 rtl/a2d_spi_resp_sync.sv | 34 +++
 rtl/a2d_spi_resp.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/a2d_spi_resp_pkg.sv
// Shared constants and state type for the A2D SPI responder.
// The frame is 16 bits and the channel number sits in bits 13:11.
package a2d_spi_pkg;

   localparam int FRAME_BITS = 16;
   localparam int CH_MSB     = 13;
   localparam int CH_LSB     = 11;
   localparam int CNT_W      = 5;

   typedef enum logic {IDLE, SHIFT} a2d_state_t;

endpackage

// File: rtl/a2d_spi_resp_sync.sv
// Two-flop synchronizer plus a history flop for one asynchronous SPI pin.
// Produces the synchronized level and single-clk rise/fall strobes.
module spi_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_preset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_hist;

   // The reset value comes from a port so idle-high pins do not fake an edge at reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= i_preset;
         r_sync <= i_preset;
         r_hist <= i_preset;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_hist <= r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_sync & ~r_hist;
   assign o_fall  = ~r_sync & r_hist;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI slave modelling an 8-channel A2D: decodes the channel command in each
// frame and returns that channel's conversion during the following frame.
module a2d_spi_resp
   import a2d_spi_pkg::*;
#(
   parameter int DATA_W = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  SS_n,
   input  logic                  SCLK,
   input  logic                  MOSI,
   output logic                  MISO,
   input  logic [8*DATA_W-1:0]   chan_val,
   output logic                  cmd_vld,
   output logic [2:0]            cmd_ch,
   output logic                  frm_err
);

   logic w_ssLevel, w_ssRise, w_ssFall;
   logic w_sclkLevel, w_sclkRise, w_sclkFall;
   logic w_mosiLevel, w_mosiRise, w_mosiFall;
   logic w_unusedSync;

   spi_sync_edge u_syncSs (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_preset (1'b1),
      .i_async  (SS_n),
      .o_level  (w_ssLevel),
      .o_rise   (w_ssRise),
      .o_fall   (w_ssFall)
   );

   spi_sync_edge u_syncSclk (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_preset (1'b1),
      .i_async  (SCLK),
      .o_level  (w_sclkLevel),
      .o_rise   (w_sclkRise),
      .o_fall   (w_sclkFall)
   );

   spi_sync_edge u_syncMosi (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_preset (1'b0),
      .i_async  (MOSI),
      .o_level  (w_mosiLevel),
      .o_rise   (w_mosiRise),
      .o_fall   (w_mosiFall)
   );

   assign w_unusedSync = ^{w_sclkLevel, w_mosiRise, w_mosiFall};

   a2d_state_t             r_state;
   a2d_state_t             w_stateNxt;
   logic [CH_MSB:0]        r_rxShft;
   logic [FRAME_BITS-1:0]  r_txShft;
   logic [CNT_W-1:0]       r_bitCnt;
   logic                   r_seenRise;
   logic [DATA_W-1:0]      r_hold;
   logic [1:0]             r_flushCnt;
   logic                   r_armed;
   logic                   w_enter;
   logic                   w_sample;
   logic                   w_shiftTx;
   logic                   w_endOk;
   logic                   w_endErr;
   logic [2:0]             w_rxCh;

   assign w_rxCh = r_rxShft[CH_MSB:CH_LSB];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_stateNxt;
   end

   always_comb begin
      w_stateNxt = r_state;
      case (r_state)
         IDLE:    if (r_armed && w_ssFall) w_stateNxt = SHIFT;
         SHIFT:   if (w_ssRise)            w_stateNxt = IDLE;
         default: w_stateNxt = IDLE;
      endcase
   end

   // An SS_n rise takes priority over any SCLK edge seen on the same clk
   always_comb begin
      w_enter   = 1'b0;
      w_sample  = 1'b0;
      w_shiftTx = 1'b0;
      w_endOk   = 1'b0;
      w_endErr  = 1'b0;
      case (r_state)
         IDLE: w_enter = r_armed && w_ssFall;
         SHIFT: begin
            if (w_ssRise) begin
               w_endOk  = (r_bitCnt == CNT_W'(FRAME_BITS));
               w_endErr = (r_bitCnt != CNT_W'(FRAME_BITS));
            end else begin
               w_sample  = w_sclkRise;
               w_shiftTx = w_sclkFall && r_seenRise;
            end
         end
         default: ;
      endcase
   end

   // Frames are only accepted once SS_n has been seen high after the synchronizer flushed its preset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flushCnt <= '0;
         r_armed    <= 1'b0;
      end else begin
         if (r_flushCnt != 2'd2) r_flushCnt <= r_flushCnt + 2'd1;
         if (r_flushCnt == 2'd2 && w_ssLevel) r_armed <= 1'b1;
      end
   end

   // Bit count stops one past a full frame so an overrun still reads as an error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rxShft   <= '0;
         r_txShft   <= '0;
         r_bitCnt   <= '0;
         r_seenRise <= 1'b0;
         r_hold     <= '0;
         cmd_ch     <= '0;
         cmd_vld    <= 1'b0;
         frm_err    <= 1'b0;
      end else begin
         cmd_vld <= w_endOk;
         frm_err <= w_endErr;
         if (w_enter) begin
            r_txShft   <= FRAME_BITS'(r_hold);
            r_bitCnt   <= '0;
            r_seenRise <= 1'b0;
         end
         if (w_sample) begin
            r_rxShft   <= {r_rxShft[CH_MSB-1:0], w_mosiLevel};
            r_seenRise <= 1'b1;
            if (r_bitCnt != CNT_W'(FRAME_BITS + 1)) r_bitCnt <= r_bitCnt + 1'b1;
         end
         if (w_shiftTx) r_txShft <= {r_txShft[FRAME_BITS-2:0], 1'b0};
         if (w_endOk) begin
            cmd_ch <= w_rxCh;
            r_hold <= chan_val[w_rxCh*DATA_W +: DATA_W];
         end
      end
   end

   assign MISO = w_ssLevel ? 1'b0 : r_txShft[FRAME_BITS-1];

endmodule
